toy_bus_dmrg2ch: RTL and testbench

TOY_BUS_DMRG2CH -- requirements
Module: toy_bus_dmrg2ch

---
 rtl/toy_bus_pkg.sv | 24 ++
 rtl/toy_bus_rr_arb2.sv | 18 +
 rtl/toy_bus_dmrg2ch.sv | 134 +++++++++++++
 tb/tb_toy_bus_dmrg2ch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// toy_bus_pkg: shared toy bus payload widths and request/ack payload structs
package toy_bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int OP_W   = 1;
    localparam int ID_W   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
        logic [OP_W-1:0]   opcode;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
    } toy_bus_req_t;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
    } toy_bus_ack_t;
endpackage

// File: rtl/toy_bus_rr_arb2.sv
// toy_bus_rr_arb2: 2-way round-robin arbiter, priority flips to the other port after each advance
module toy_bus_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);
    logic prio;

    always_comb grant = (req == 2'b11) ? (prio ? 2'b10 : 2'b01) : req;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            prio <= 1'b0;
        else if (adv)
            prio <= grant[0];
endmodule

// File: rtl/toy_bus_dmrg2ch.sv
// toy_bus_dmrg2ch: 2-initiator toy bus merge with one-entry request slice, per-port outstanding limit and ack demux
module toy_bus_dmrg2ch import toy_bus_pkg::*; #(
    parameter logic [ID_W-1:0] IN0_ID  = 4'd0,
    parameter logic [ID_W-1:0] IN1_ID  = 4'd1,
    parameter int              MAX_OST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_req_vld,
    output logic              in0_req_rdy,
    input  logic [ADDR_W-1:0] in0_req_addr,
    input  logic [STRB_W-1:0] in0_req_strb,
    input  logic [DATA_W-1:0] in0_req_data,
    input  logic [OP_W-1:0]   in0_req_opcode,
    input  logic [ID_W-1:0]   in0_req_src_id,
    input  logic [ID_W-1:0]   in0_req_tgt_id,
    output logic              in0_ack_vld,
    input  logic              in0_ack_rdy,
    output logic [OP_W-1:0]   in0_ack_opcode,
    output logic [DATA_W-1:0] in0_ack_data,
    output logic [ID_W-1:0]   in0_ack_src_id,
    output logic [ID_W-1:0]   in0_ack_tgt_id,
    input  logic              in1_req_vld,
    output logic              in1_req_rdy,
    input  logic [ADDR_W-1:0] in1_req_addr,
    input  logic [STRB_W-1:0] in1_req_strb,
    input  logic [DATA_W-1:0] in1_req_data,
    input  logic [OP_W-1:0]   in1_req_opcode,
    input  logic [ID_W-1:0]   in1_req_src_id,
    input  logic [ID_W-1:0]   in1_req_tgt_id,
    output logic              in1_ack_vld,
    input  logic              in1_ack_rdy,
    output logic [OP_W-1:0]   in1_ack_opcode,
    output logic [DATA_W-1:0] in1_ack_data,
    output logic [ID_W-1:0]   in1_ack_src_id,
    output logic [ID_W-1:0]   in1_ack_tgt_id,
    output logic              out_req_vld,
    input  logic              out_req_rdy,
    output logic [ADDR_W-1:0] out_req_addr,
    output logic [STRB_W-1:0] out_req_strb,
    output logic [DATA_W-1:0] out_req_data,
    output logic [OP_W-1:0]   out_req_opcode,
    output logic [ID_W-1:0]   out_req_src_id,
    output logic [ID_W-1:0]   out_req_tgt_id,
    input  logic              out_ack_vld,
    output logic              out_ack_rdy,
    input  logic [OP_W-1:0]   out_ack_opcode,
    input  logic [DATA_W-1:0] out_ack_data,
    input  logic [ID_W-1:0]   out_ack_src_id,
    input  logic [ID_W-1:0]   out_ack_tgt_id,
    output logic              err_unmapped
);
    localparam int CW = $clog2(MAX_OST + 1);

    toy_bus_req_t   req0, req1, slot_q;
    logic           slot_vld_q, slot_accept, load;
    logic [1:0]     req_vld, eligible, grant, req_hs, ack_hs, cnt_zero;
    logic           sel0, sel1, unmapped;
    logic [CW-1:0]  ost_cnt [2];

    assign req0 = '{addr: in0_req_addr, strb: in0_req_strb, data: in0_req_data,
                    opcode: in0_req_opcode, src_id: in0_req_src_id, tgt_id: in0_req_tgt_id};
    assign req1 = '{addr: in1_req_addr, strb: in1_req_strb, data: in1_req_data,
                    opcode: in1_req_opcode, src_id: in1_req_src_id, tgt_id: in1_req_tgt_id};
    assign req_vld = {in1_req_vld, in0_req_vld};

    toy_bus_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eligible),
        .adv   (load),
        .grant (grant)
    );

    // rst_n gating keeps rdy low while reset is held, even though the empty slot would accept
    assign slot_accept = (~slot_vld_q | out_req_rdy) & rst_n;
    assign in0_req_rdy = grant[0] & slot_accept;
    assign in1_req_rdy = grant[1] & slot_accept;
    assign req_hs      = {in1_req_vld & in1_req_rdy, in0_req_vld & in0_req_rdy};
    assign load        = |req_hs;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            slot_vld_q <= 1'b0;
            slot_q     <= '0;
        end else if (load) begin
            slot_vld_q <= 1'b1;
            slot_q     <= grant[1] ? req1 : req0;
        end else if (out_req_rdy) begin
            slot_vld_q <= 1'b0;
        end

    assign out_req_vld    = slot_vld_q;
    assign out_req_addr   = slot_q.addr;
    assign out_req_strb   = slot_q.strb;
    assign out_req_data   = slot_q.data;
    assign out_req_opcode = slot_q.opcode;
    assign out_req_src_id = slot_q.src_id;
    assign out_req_tgt_id = slot_q.tgt_id;

    assign sel0     = out_ack_tgt_id == IN0_ID;
    assign sel1     = out_ack_tgt_id == IN1_ID;
    assign unmapped = ~sel0 & ~sel1;

    assign in0_ack_vld    = out_ack_vld & sel0;
    assign in1_ack_vld    = out_ack_vld & sel1;
    assign out_ack_rdy    = sel0 ? in0_ack_rdy : sel1 ? in1_ack_rdy : 1'b1;
    assign in0_ack_opcode = out_ack_opcode;
    assign in0_ack_data   = out_ack_data;
    assign in0_ack_src_id = out_ack_src_id;
    assign in0_ack_tgt_id = out_ack_tgt_id;
    assign in1_ack_opcode = out_ack_opcode;
    assign in1_ack_data   = out_ack_data;
    assign in1_ack_src_id = out_ack_src_id;
    assign in1_ack_tgt_id = out_ack_tgt_id;
    assign ack_hs         = {in1_ack_vld & in1_ack_rdy, in0_ack_vld & in0_ack_rdy};

    for (genvar i = 0; i < 2; i++) begin : g_ost
        assign cnt_zero[i] = ost_cnt[i] == '0;
        assign eligible[i] = req_vld[i] & (ost_cnt[i] < CW'(MAX_OST));
        // an ack with nothing outstanding is forwarded but must not wrap the counter
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)
                ost_cnt[i] <= '0;
            else
                ost_cnt[i] <= ost_cnt[i] + CW'(req_hs[i]) - CW'(ack_hs[i] & ~cnt_zero[i]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            err_unmapped <= 1'b0;
        else if ((out_ack_vld & unmapped) | |(ack_hs & cnt_zero))
            err_unmapped <= 1'b1;
endmodule

// File: tb/tb_toy_bus_dmrg2ch.sv
// tb_toy_bus_dmrg2ch: randomized check of toy_bus_dmrg2ch against a transaction-level reference model
module tb_toy_bus_dmrg2ch;
    localparam logic [3:0] ID0  = 4'd3;
    localparam logic [3:0] ID1  = 4'd9;
    localparam int         MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_vld, req_rdy, ack_vld, ack_rdy;
    logic [31:0] req_addr [2];
    logic [3:0]  req_strb [2];
    logic [31:0] req_data [2];
    logic [0:0]  req_op   [2];
    logic [3:0]  req_src  [2];
    logic [3:0]  req_tgt  [2];
    logic [0:0]  ack_op   [2];
    logic [31:0] ack_data [2];
    logic [3:0]  ack_src  [2];
    logic [3:0]  ack_tgt  [2];
    logic        out_req_vld, out_req_rdy, out_ack_vld, out_ack_rdy, err_unmapped;
    logic [31:0] out_req_addr, out_req_data, out_ack_data;
    logic [3:0]  out_req_strb, out_req_src_id, out_req_tgt_id, out_ack_src_id, out_ack_tgt_id;
    logic [0:0]  out_req_opcode, out_ack_opcode;

    int          n_chk = 0;
    int          n_err = 0;
    bit          m_vld, m_err;
    logic [76:0] m_pay;
    int          m_prio;
    int          m_cnt [2];

    always #5 clk = ~clk;

    toy_bus_dmrg2ch #(.IN0_ID(ID0), .IN1_ID(ID1), .MAX_OST(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_req_vld(req_vld[0]), .in0_req_rdy(req_rdy[0]), .in0_req_addr(req_addr[0]),
        .in0_req_strb(req_strb[0]), .in0_req_data(req_data[0]), .in0_req_opcode(req_op[0]),
        .in0_req_src_id(req_src[0]), .in0_req_tgt_id(req_tgt[0]),
        .in0_ack_vld(ack_vld[0]), .in0_ack_rdy(ack_rdy[0]), .in0_ack_opcode(ack_op[0]),
        .in0_ack_data(ack_data[0]), .in0_ack_src_id(ack_src[0]), .in0_ack_tgt_id(ack_tgt[0]),
        .in1_req_vld(req_vld[1]), .in1_req_rdy(req_rdy[1]), .in1_req_addr(req_addr[1]),
        .in1_req_strb(req_strb[1]), .in1_req_data(req_data[1]), .in1_req_opcode(req_op[1]),
        .in1_req_src_id(req_src[1]), .in1_req_tgt_id(req_tgt[1]),
        .in1_ack_vld(ack_vld[1]), .in1_ack_rdy(ack_rdy[1]), .in1_ack_opcode(ack_op[1]),
        .in1_ack_data(ack_data[1]), .in1_ack_src_id(ack_src[1]), .in1_ack_tgt_id(ack_tgt[1]),
        .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy), .out_req_addr(out_req_addr),
        .out_req_strb(out_req_strb), .out_req_data(out_req_data), .out_req_opcode(out_req_opcode),
        .out_req_src_id(out_req_src_id), .out_req_tgt_id(out_req_tgt_id),
        .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy), .out_ack_opcode(out_ack_opcode),
        .out_ack_data(out_ack_data), .out_ack_src_id(out_ack_src_id), .out_ack_tgt_id(out_ack_tgt_id),
        .err_unmapped(err_unmapped)
    );

    task automatic check(input string tag, input logic [76:0] got, input logic [76:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [76:0] pay(input int n);
        return {req_addr[n], req_strb[n], req_data[n], req_op[n], req_src[n], req_tgt[n]};
    endfunction

    task automatic model_reset();
        m_vld  = 0;
        m_err  = 0;
        m_prio = 0;
        m_cnt  = '{0, 0};
    endtask

    task automatic idle_inputs();
        req_vld     = '0;
        ack_rdy     = '0;
        out_req_rdy = 1'b0;
        out_ack_vld = 1'b0;
        out_ack_tgt_id = 4'hF;
    endtask

    // one cycle: drive random inputs, check every output against the model, advance the model
    task automatic step(input int ack_pct);
        int  g, r;
        bit  e0, e1, acc, s0, s1;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            req_vld[n]  = $urandom_range(0, 3) != 0;
            req_addr[n] = $urandom;
            req_strb[n] = 4'($urandom);
            req_data[n] = $urandom;
            req_op[n]   = 1'($urandom);
            req_src[n]  = 4'($urandom);
            req_tgt[n]  = 4'($urandom);
            ack_rdy[n]  = $urandom_range(0, 2) != 0;
        end
        out_req_rdy    = $urandom_range(0, 3) != 0;
        out_ack_vld    = $urandom_range(0, 99) < ack_pct;
        r              = $urandom_range(0, 9);
        out_ack_tgt_id = r < 4 ? ID0 : r < 8 ? ID1 : 4'hF;
        out_ack_opcode = 1'($urandom);
        out_ack_data   = $urandom;
        out_ack_src_id = 4'($urandom);
        #1;
        e0  = req_vld[0] && m_cnt[0] < MAXO;
        e1  = req_vld[1] && m_cnt[1] < MAXO;
        acc = !m_vld || out_req_rdy;
        g   = (e0 && e1) ? m_prio : e0 ? 0 : e1 ? 1 : -1;
        s0  = out_ack_tgt_id == ID0;
        s1  = out_ack_tgt_id == ID1;
        check("in0_req_rdy", req_rdy[0], acc && g == 0);
        check("in1_req_rdy", req_rdy[1], acc && g == 1);
        check("out_req_vld", out_req_vld, m_vld);
        if (m_vld)
            check("out_req_payload", {out_req_addr, out_req_strb, out_req_data, out_req_opcode,
                  out_req_src_id, out_req_tgt_id}, m_pay);
        check("in0_ack_vld", ack_vld[0], out_ack_vld && s0);
        check("in1_ack_vld", ack_vld[1], out_ack_vld && s1);
        check("out_ack_rdy", out_ack_rdy, s0 ? ack_rdy[0] : s1 ? ack_rdy[1] : 1'b1);
        if (s0 || s1)
            check("ack_payload", {ack_op[s1], ack_data[s1], ack_src[s1], ack_tgt[s1]},
                  {out_ack_opcode, out_ack_data, out_ack_src_id, out_ack_tgt_id});
        check("err_unmapped", err_unmapped, m_err);
        if (out_ack_vld) begin
            if (!s0 && !s1)
                m_err = 1;
            else if (ack_rdy[s1]) begin
                if (m_cnt[s1] == 0) m_err = 1;
                else m_cnt[s1]--;
            end
        end
        if (g >= 0 && acc) begin
            m_pay  = pay(g);
            m_vld  = 1;
            m_prio = 1 - g;
            m_cnt[g]++;
        end else if (out_req_rdy)
            m_vld = 0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_req_vld", out_req_vld, 1'b0);
        check("rst_in0_req_rdy", req_rdy[0], 1'b0);
        check("rst_in1_req_rdy", req_rdy[1], 1'b0);
        check("rst_err", err_unmapped, 1'b0);
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            req_addr[n] = '0; req_strb[n] = '0; req_data[n] = '0;
            req_op[n] = '0; req_src[n] = '0; req_tgt[n] = '0;
        end
        out_ack_opcode = '0;
        out_ack_data   = '0;
        out_ack_src_id = '0;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        req_vld = 2'b11;
        #1;
        check("reset_out_req_vld", out_req_vld, 1'b0);
        check("reset_in0_req_rdy", req_rdy[0], 1'b0);
        check("reset_in1_req_rdy", req_rdy[1], 1'b0);
        check("reset_err", err_unmapped, 1'b0);
        req_vld = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) step(30);
        mid_reset();
        repeat (400) step(60);
        mid_reset();
        repeat (200) step(15);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
